bam_ctrl: RTL

BAM_CTRL -- requirements
Module: bam_ctrl

---
 rtl/bam_pkg.sv | 50 +++++
 rtl/bam_instr_fifo.sv | 52 +++++
 rtl/bam_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/bam_pkg.sv
// Shared encodings for the BAM controller: instruction layout, modes, FSM states.
package bam_pkg;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int INSTR_W        = 32;

    localparam int MODE_HI = 31, MODE_LO = 30;
    localparam int OP_HI   = 29, OP_LO   = 27;
    localparam int RS1_HI  = 26, RS1_LO  = 22;
    localparam int RS2_HI  = 21, RS2_LO  = 17;
    localparam int ADDR_HI = 16, ADDR_LO = 12;
    localparam int RD_HI   = 11, RD_LO   = 7;
    localparam int IMM_HI  = 6,  IMM_LO  = 0;

    typedef enum logic [1:0] {
        MODE_ALU  = 2'b00,
        MODE_LOAD = 2'b01,
        MODE_LI   = 2'b10,
        MODE_ILL  = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_READ,
        ST_WB,
        ST_DONE
    } state_e;

    typedef struct packed {
        mode_e      mode;
        logic [2:0] op;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] addr;
        logic [4:0] rd;
        logic [6:0] imm;
    } instr_t;

    function automatic instr_t decode(input logic [INSTR_W-1:0] w);
        instr_t d;
        d.mode = mode_e'(w[MODE_HI:MODE_LO]);
        d.op   = w[OP_HI:OP_LO];
        d.rs1  = w[RS1_HI:RS1_LO];
        d.rs2  = w[RS2_HI:RS2_LO];
        d.addr = w[ADDR_HI:ADDR_LO];
        d.rd   = w[RD_HI:RD_LO];
        d.imm  = w[IMM_HI:IMM_LO];
        return d;
    endfunction
endpackage

// File: rtl/bam_instr_fifo.sv
// Instruction queue: synchronous first-word-fall-through FIFO, head on o_dat while !o_empty.
// A write while full is dropped, even when a read frees a slot in the same cycle.
module bam_instr_fifo
    import bam_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF,
    parameter int W     = INSTR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_dat,
    input  logic         i_pop,
    output logic [W-1:0] o_dat,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_wr;
    logic          w_rd;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_wr    = i_push && !o_full;
    assign w_rd    = i_pop && !o_empty;
    assign o_dat   = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_dat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/bam_ctrl.sv
// BAM controller: queues instruction words and sequences register-bank / ALU / memory control.
// All control outputs are registered; they are set on entry to the state that owns them.
module bam_ctrl
    import bam_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [4:0]  ctl_ra1,
    output logic [4:0]  ctl_ra2,
    output logic [2:0]  ctl_sel,
    output logic [4:0]  ctl_dir1,
    output logic        ctl_ewr,
    output logic [4:0]  ctl_dir2,
    output logic        ctl_regwrite,
    output logic [31:0] ctl_di,
    input  logic        dp_zf,
    input  logic [31:0] dp_dout,
    output logic        busy,
    output logic        done,
    output logic        zf_last,
    output logic        err,
    input  logic        err_clr,
    output logic [15:0] retired
);
    state_e      r_state;
    logic [4:0]  r_rd;
    logic [4:0]  r_ra1, r_ra2, r_dir1, r_dir2;
    logic [2:0]  r_sel;
    logic        r_ewr, r_regwrite, r_done, r_zf_last, r_err;
    logic [31:0] r_di;
    logic [15:0] r_retired;

    logic [31:0] w_head;
    logic        w_full, w_empty, w_push, w_pop;
    instr_t      w_dec;

    assign instr_ready = !rst && !w_full;
    assign w_push      = instr_valid && instr_ready;
    assign w_pop       = (r_state == ST_IDLE) && !w_empty;
    assign w_dec       = decode(w_head);

    bam_instr_fifo #(.DEPTH(FIFO_DEPTH), .W(INSTR_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_dat   (instr),
        .i_pop   (w_pop),
        .o_dat   (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rd       <= '0;
            r_ra1      <= '0;
            r_ra2      <= '0;
            r_sel      <= '0;
            r_dir1     <= '0;
            r_ewr      <= 1'b0;
            r_dir2     <= '0;
            r_regwrite <= 1'b0;
            r_di       <= '0;
            r_done     <= 1'b0;
            r_zf_last  <= 1'b0;
            r_err      <= 1'b0;
            r_retired  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_rd <= w_dec.rd;
                        case (w_dec.mode)
                            MODE_ALU: begin
                                r_ra1   <= w_dec.rs1;
                                r_ra2   <= w_dec.rs2;
                                r_sel   <= w_dec.op;
                                r_dir1  <= w_dec.addr;
                                r_ewr   <= 1'b1;
                                r_state <= ST_EXEC;
                            end
                            MODE_LOAD: begin
                                r_dir1  <= w_dec.addr;
                                r_state <= ST_READ;
                            end
                            MODE_LI: begin
                                r_dir2     <= w_dec.rd;
                                r_regwrite <= 1'b1;
                                r_di       <= {25'd0, w_dec.imm};
                                r_state    <= ST_WB;
                            end
                            default: begin
                                // Illegal mode retires straight away with only the error flag raised
                                r_err     <= 1'b1;
                                r_done    <= 1'b1;
                                r_retired <= r_retired + 16'd1;
                                r_state   <= ST_DONE;
                            end
                        endcase
                    end
                end
                ST_EXEC: begin
                    r_ra1     <= '0;
                    r_ra2     <= '0;
                    r_sel     <= '0;
                    r_dir1    <= '0;
                    r_ewr     <= 1'b0;
                    r_zf_last <= dp_zf;
                    r_done    <= 1'b1;
                    r_retired <= r_retired + 16'd1;
                    r_state   <= ST_DONE;
                end
                ST_READ: begin
                    // ctl_di doubles as the latch for the memory read data
                    r_dir1     <= '0;
                    r_dir2     <= r_rd;
                    r_regwrite <= 1'b1;
                    r_di       <= dp_dout;
                    r_state    <= ST_WB;
                end
                ST_WB: begin
                    r_dir2     <= '0;
                    r_regwrite <= 1'b0;
                    r_di       <= '0;
                    r_done     <= 1'b1;
                    r_retired  <= r_retired + 16'd1;
                    r_state    <= ST_DONE;
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
            if (err_clr) r_err <= 1'b0;
        end
    end

    assign ctl_ra1      = r_ra1;
    assign ctl_ra2      = r_ra2;
    assign ctl_sel      = r_sel;
    assign ctl_dir1     = r_dir1;
    assign ctl_ewr      = r_ewr;
    assign ctl_dir2     = r_dir2;
    assign ctl_regwrite = r_regwrite;
    assign ctl_di       = r_di;
    assign done         = r_done;
    assign zf_last      = r_zf_last;
    assign err          = r_err;
    assign retired      = r_retired;
    assign busy         = (r_state != ST_IDLE) || !w_empty;
endmodule
